// File: rtl/tone_detector.sv
// tone_detector
//   Measures an incoming square-wave tone in clk cycles. A note is declared
//   (LOCKED) once STABLE_N consecutive periods agree within TOL, and its
//   period is reported. Note start/end pulses and a wrapping note counter
//   are provided; a gap of SILENCE_CYC cycles without a rising edge is
//   treated as silence.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | silent; counter held at 0, waiting for a first rising edge
//   ARM    | first edge seen, timing the first full period
//   ACQ    | collecting consecutive matching periods against ref_q
//   LOCKED | note declared; period output valid, checking pitch holds
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tone_in     asynchronous square-wave tone input
//   period      locked note period (held after note end)
//   note_valid  high while LOCKED
//   note_start  one-cycle pulse on entering LOCKED
//   note_end    one-cycle pulse on leaving LOCKED
//   note_count  number of notes locked since reset, wraps at 255
module tone_detector #(
  parameter int CNT_W       = 18,
  parameter int TOL         = 4,
  parameter int STABLE_N    = 3,
  parameter int MIN_PERIOD  = 64,
  parameter int SILENCE_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             note_valid,
  output logic             note_start,
  output logic             note_end,
  output logic [7:0]       note_count
);

  localparam int MW = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] SIL_LAST = CNT_W'(SILENCE_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);
  localparam logic [MW-1:0]    LOCK_N   = MW'(STABLE_N);

  typedef enum logic [1:0] {IDLE, ARM, ACQ, LOCKED} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ref_q;
  logic [CNT_W-1:0] period_q;
  logic [MW-1:0]    match_q;
  logic             valid_q, start_q, end_q;
  logic [7:0]       count_q;

  logic             rise_d;
  logic             timeout_d;
  logic             ref_hit_d;
  logic             per_hit_d;
  logic [CNT_W-1:0] sample_d;
  logic [MW-1:0]    match_inc_d;

  // Difference is taken one bit wider than the counter so it never wraps.
  function automatic logic pitch_match(input logic [CNT_W-1:0] s,
                                       input logic [CNT_W-1:0] x);
    logic [CNT_W:0] diff;
    diff = {1'b0, s} - {1'b0, x};
    if (diff[CNT_W]) diff = -diff;
    return (s >= MIN_W) && (diff <= TOL_W);
  endfunction

  always_comb begin
    rise_d      = s2_q & ~s3_q;
    // Saturating cnt+1 doubles as the period sample taken on a rise.
    sample_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    timeout_d   = (cnt_q == SIL_LAST) && !rise_d;
    match_inc_d = match_q + 1'b1;
    ref_hit_d   = pitch_match(sample_d, ref_q);
    per_hit_d   = pitch_match(sample_d, period_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_q    <= tone_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      start_q <= 1'b0;
      end_q   <= 1'b0;

      // Outside IDLE the counter runs and a rise restarts it; timeout
      // branches below override it back to 0.
      if (state_q != IDLE) begin
        cnt_q <= rise_d ? '0 : sample_d;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise_d) state_q <= ARM;
        end

        ARM: begin
          if (rise_d) begin
            state_q <= ACQ;
            ref_q   <= sample_d;
            match_q <= MW'(1);
          end else if (timeout_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end

        ACQ: begin
          if (rise_d) begin
            if (ref_hit_d) begin
              match_q <= match_inc_d;
              if (match_inc_d == LOCK_N) begin
                state_q  <= LOCKED;
                period_q <= sample_d;
                valid_q  <= 1'b1;
                start_q  <= 1'b1;
                count_q  <= count_q + 8'd1;
              end
            end else begin
              ref_q   <= sample_d;
              match_q <= MW'(1);
            end
          end else if (timeout_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end

        LOCKED: begin
          if (rise_d) begin
            // No drift tracking: period_q stays at the value it locked on.
            if (!per_hit_d) begin
              state_q <= ACQ;
              ref_q   <= sample_d;
              match_q <= MW'(1);
              valid_q <= 1'b0;
              end_q   <= 1'b1;
            end
          end else if (timeout_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign note_valid = valid_q;
  assign note_start = start_q;
  assign note_end   = end_q;
  assign note_count = count_q;

endmodule

// File: tb/tb_tone_detector.sv
// Testbench for tone_detector. A tone generator drives rising edges at
// chosen spacings; a sample-level reference model predicts each note_start /
// note_end pulse (kind, cycle, period, count) and queues it; a monitor pops
// and compares whenever the DUT pulses. Periods are scaled down from audio
// values so the run stays short.
module tb_tone_detector;

  localparam int CNT_W    = 12;
  localparam int TOL      = 4;
  localparam int STABLE_N = 3;
  localparam int MIN_P    = 32;
  localparam int SIL      = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             note_valid, note_start, note_end;
  logic [7:0]       note_count;

  tone_detector #(
    .CNT_W(CNT_W), .TOL(TOL), .STABLE_N(STABLE_N),
    .MIN_PERIOD(MIN_P), .SILENCE_CYC(SIL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in),
    .period(period), .note_valid(note_valid), .note_start(note_start),
    .note_end(note_end), .note_count(note_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 1 = start, 2 = end
    int cyc;
    int per;
    int cnt;
  } ev_t;
  ev_t exp_q[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (works on sample periods) ----------
  bit heard  = 0;     // first edge since silence/reset already seen
  bit locked = 0;
  int run[$];         // current run of samples; run[0] is the reference
  int m_per  = 0;
  int m_cnt  = 0;
  int last_drive = 0;

  function automatic bit same_pitch(input int s, input int x);
    int d;
    d = (s > x) ? s - x : x - s;
    return (s >= MIN_P) && (d <= TOL);
  endfunction

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind; e.cyc = c; e.per = m_per; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic model_timeout(input int c);
    if (locked) push_ev(2, c);
    locked = 0;
    heard  = 0;
    run.delete();
  endtask

  task automatic model_reset();
    heard = 0; locked = 0; run.delete(); m_per = 0; m_cnt = 0;
  endtask

  // d is the cycle on which tone_in was driven high; effects land at d+3.
  task automatic model_rise(input int d);
    int s;
    if (!heard) begin
      heard = 1;
      run.delete();
    end else begin
      s = d - last_drive;
      if (locked) begin
        if (!same_pitch(s, m_per)) begin
          locked = 0;
          push_ev(2, d + 3);
          run.delete();
          run.push_back(s);
        end
      end else if (run.size() == 0) begin
        run.push_back(s);
      end else if (same_pitch(s, run[0])) begin
        run.push_back(s);
        if (run.size() == STABLE_N) begin
          locked = 1;
          m_per  = s;
          m_cnt  = (m_cnt + 1) % 256;
          push_ev(1, d + 3);
        end
      end else begin
        run.delete();
        run.push_back(s);
      end
    end
    last_drive = d;
  endtask

  // ---------------- tone generator ------------------------------------
  task automatic rise_in(input int spacing, input int hi);
    int target;
    target = last_drive + spacing;
    if (heard && spacing > SIL) model_timeout(last_drive + 3 + SIL);
    do begin
      @(posedge clk); #1;
    end while (cyc < target);
    tone_in = 1'b1;
    model_rise(cyc);
    repeat (hi) @(posedge clk);
    #1 tone_in = 1'b0;
  endtask

  task automatic tone(input int n, input int spacing);
    for (int i = 0; i < n; i++) rise_in(spacing, spacing / 2);
  endtask

  task automatic go_silent();
    if (heard) model_timeout(last_drive + 3 + SIL);
    repeat (SIL + 10) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, int'(note_valid), int'(locked));
    chk({tag, "_period"}, int'(period), m_per);
    chk({tag, "_count"}, int'(note_count), m_cnt);
  endtask

  // ---------------- monitor -------------------------------------------
  always @(negedge clk) begin
    if (rst_n && (note_start || note_end)) begin
      chk("pulse_exclusive", int'(note_start && note_end), 0);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: start=%0d end=%0d at cycle %0d, none expected",
                 note_start, note_end, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", note_start ? 1 : 2, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_period", int'(period), e.per);
        chk("pulse_count", int'(note_count), e.cnt);
        chk("pulse_valid", int'(note_valid), (e.kind == 1) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ------------------------------------------
  int base, r, sp, cnt_before;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_start", int'(note_start), 0);
    chk("rst_end", int'(note_end), 0);
    chk("rst_count", int'(note_count), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_drive = cyc;

    // Clean tone: locks on the 4th rise.
    tone(6, 472);
    check_state("lock472");
    chk("lock472_period_abs", int'(period), 472);

    // Jitter within tolerance on alternate periods.
    for (int i = 0; i < 8; i++) begin
      sp = (i % 2) ? 472 + int'($urandom_range(8, 0)) - 4 : 472;
      rise_in(sp, 200);
    end
    check_state("jitter");

    // Legato pitch change.
    tone(6, 421);
    check_state("legato");
    chk("legato_count_abs", int'(note_count), 2);

    // Silence, then relock.
    go_silent();
    check_state("silence");
    tone(4, 472);
    check_state("relock");
    go_silent();

    // Gap of exactly SIL (rise wins) and SIL+1 (timeout first).
    tone(4, 300);
    rise_in(SIL, 150);
    tone(3, 300);
    check_state("sil_edge");
    rise_in(SIL + 1, 150);
    check_state("sil_over");
    go_silent();

    // Just below and at the minimum period.
    tone(8, MIN_P - 1);
    check_state("below_min");
    tone(4, MIN_P);
    check_state("at_min");
    go_silent();

    // Glitch pulses every 3rd period.
    cnt_before = m_cnt;
    for (int p = 0; p < 9; p++) begin
      if (p % 3 == 2) begin
        rise_in(150, 20);
        rise_in(322, 100);
      end else begin
        rise_in(472, 100);
      end
    end
    check_state("glitch");
    chk("glitch_no_lock", int'(note_count), cnt_before);
    go_silent();

    // Randomized spacings, including glitches and silence-boundary gaps.
    base = 200;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) base = int'($urandom_range(300, 80));
      r = int'($urandom_range(15, 0));
      if (r == 0) sp = SIL - 1 + int'($urandom_range(2, 0));
      else if (r == 1) sp = 20;
      else sp = base + int'($urandom_range(12, 0)) - 6;
      rise_in(sp, 8);
    end
    check_state("random");
    go_silent();

    // Reset while locked: outputs clear at once, no end pulse.
    tone(4, 200);
    chk("prereset_valid", int'(note_valid), 1);
    chk("prereset_queue", exp_q.size(), 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_period", int'(period), 0);
    chk("midrst_valid", int'(note_valid), 0);
    chk("midrst_start", int'(note_start), 0);
    chk("midrst_end", int'(note_end), 0);
    chk("midrst_count", int'(note_count), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 256 notes via legato changes: count wraps to 0.
    rise_in(40, 20);
    for (int n = 0; n < 256; n++) tone(3, 32 + 8 * (n % 4));
    check_state("wrap");
    chk("wrap_count_abs", int'(note_count), 0);
    go_silent();

    repeat (20) @(posedge clk);
    #1;
    chk("events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
